// File: rtl/mmio_pkg.sv
// Shared encodings for the CPU memory-mapped I/O bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: command codes, read-source select enum, default port addresses.
package mmio_pkg;

   // CPU command encodings; 2'b11 is decoded as no access.
   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   // Source of read_data in the cycle after a READ.
   typedef enum logic [1:0] {
      SEL_ZERO = 2'd0,
      SEL_RAM  = 2'd1,
      SEL_SW   = 2'd2
   } sel_t;

   localparam logic [8:0] SW_ADDR_DEF  = 9'h140;
   localparam logic [8:0] LED_ADDR_DEF = 9'h100;

endpackage

// File: rtl/sw_debounce.sv
// Switch debouncer: 2-flop synchronizer followed by a stability counter.
// Latency: a change becomes visible on sw_stable 2 + DEBOUNCE_CYCLES cycles after it appears on sw.
// Backpressure: none; free-running every cycle.
// Ports: clk, reset (sync, active-low), sw (raw async levels), sw_stable (accepted value).
module sw_debounce #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int WIDTH           = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] sw_stable
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sw_meta;
   logic [WIDTH-1:0] sw_sync;
   logic [CNT_W-1:0] cnt;

   // The counter tracks how long the synchronized vector has disagreed with
   // the accepted value; any return to agreement restarts the count, so a
   // glitch shorter than DEBOUNCE_CYCLES never reaches sw_stable.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sw_meta   <= '0;
         sw_sync   <= '0;
         sw_stable <= '0;
         cnt       <= '0;
      end else begin
         sw_meta <= sw;
         sw_sync <= sw_meta;
         if (sw_sync != sw_stable) begin
            if (cnt == CNT_MAX) begin
               sw_stable <= sw_sync;
               cnt       <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/mmio_bridge.sv
// CPU memory-mapped I/O bridge: decodes accesses to RAM, debounced switch port and LED port.
// Latency: read_data valid exactly 1 cycle after a READ; RAM control combinational.
// Backpressure: none; one access accepted every cycle, back-to-back READs allowed.
// Ports: clk, reset (sync, active-low), mem_cmd/mem_addr/write_data (CPU), read_data (to CPU),
//        ram_addr/ram_we/ram_wdata/ram_rdata (sync-read RAM), sw (raw switches), ledr (LEDs),
//        bus_err (sticky decode error, present only when MMIO_BUSERR_EN is defined).
module mmio_bridge
   import mmio_pkg::*;
#(
   parameter int         DEBOUNCE_CYCLES = 4,
   parameter logic [8:0] SW_ADDR         = SW_ADDR_DEF,
   parameter logic [8:0] LED_ADDR        = LED_ADDR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  mem_cmd,
   input  logic [8:0]  mem_addr,
   input  logic [15:0] write_data,
   output logic [15:0] read_data,
   output logic [7:0]  ram_addr,
   output logic        ram_we,
   output logic [15:0] ram_wdata,
   input  logic [15:0] ram_rdata,
   input  logic [7:0]  sw,
`ifdef MMIO_BUSERR_EN
   output logic        bus_err,
`endif
   output logic [7:0]  ledr
);

   logic       in_ram;
   logic       is_sw;
   logic       is_led;
   logic       is_rd;
   logic       is_wr;
   sel_t       sel_d;
   sel_t       sel_q;
   logic [7:0] sw_stable;

   assign in_ram = ~mem_addr[8];
   assign is_sw  = (mem_addr == SW_ADDR);
   assign is_led = (mem_addr == LED_ADDR);
   assign is_rd  = (mem_cmd == MEM_READ);
   assign is_wr  = (mem_cmd == MEM_WRITE);

   // RAM sees the address every cycle; only the write strobe is qualified.
   // The strobe is not gated by reset so the RAM behaves the same in reset.
   assign ram_addr  = mem_addr[7:0];
   assign ram_wdata = write_data;
   assign ram_we    = is_wr & in_ram;

   always_comb begin
      sel_d = SEL_ZERO;
      if (is_rd) begin
         if (in_ram) begin
            sel_d = SEL_RAM;
         end else if (is_sw) begin
            sel_d = SEL_SW;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sel_q <= SEL_ZERO;
         ledr  <= 8'h00;
      end else begin
         sel_q <= sel_d;
         if (is_wr && is_led) begin
            ledr <= write_data[7:0];
         end
      end
   end

   // RAM data arrives one cycle after the address, so the mux is steered by
   // the registered select rather than the live decode.
   always_comb begin
      read_data = 16'h0000;
      case (sel_q)
         SEL_RAM: read_data = ram_rdata;
         SEL_SW:  read_data = {8'h00, sw_stable};
         default: read_data = 16'h0000;
      endcase
   end

   sw_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .WIDTH           (8)
   ) u_sw_debounce (
      .clk       (clk),
      .reset     (reset),
      .sw        (sw),
      .sw_stable (sw_stable)
   );

`ifdef MMIO_BUSERR_EN
   logic unmapped;
   logic err_hit;

   assign unmapped = ~in_ram & ~is_sw & ~is_led;
   assign err_hit  = ((is_rd | is_wr) & unmapped) | (is_wr & is_sw);

   always_ff @(posedge clk) begin
      if (!reset) begin
         bus_err <= 1'b0;
      end else if (err_hit) begin
         bus_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed vector table, hand-written debounce
// sequences and randomized traffic checked against a behavioural model.
// Ports of the DUT are all connected; bus_err is checked when MMIO_BUSERR_EN is defined.
module tb_mmio_bridge;
   import mmio_pkg::*;

   localparam int DEB = 4;

   logic        clk;
   logic        reset;
   logic [1:0]  mem_cmd;
   logic [8:0]  mem_addr;
   logic [15:0] write_data;
   logic [15:0] read_data;
   logic [7:0]  ram_addr;
   logic        ram_we;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic [7:0]  sw;
   logic [7:0]  ledr;
`ifdef MMIO_BUSERR_EN
   logic        bus_err;
`endif

   mmio_bridge #(
      .DEBOUNCE_CYCLES (DEB),
      .SW_ADDR         (9'h140),
      .LED_ADDR        (9'h100)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_cmd    (mem_cmd),
      .mem_addr   (mem_addr),
      .write_data (write_data),
      .read_data  (read_data),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .sw         (sw),
`ifdef MMIO_BUSERR_EN
      .bus_err    (bus_err),
`endif
      .ledr       (ledr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous-read RAM attached to the bridge.
   logic [15:0] tb_ram [256];
   always @(posedge clk) begin
      if (ram_we) tb_ram[ram_addr] <= ram_wdata;
      ram_rdata <= tb_ram[ram_addr];
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [15:0] shadow [256];   // what the RAM should hold
   logic [7:0]  hist [$];       // switch values still in flight through the synchronizer
   logic [7:0]  m_stable;
   int          m_run;          // consecutive cycles the synchronized value differed
   logic [7:0]  m_led;
   logic [15:0] m_rd;
   logic        m_err;

   task automatic model_edge(input logic rst, input logic [1:0] cmd, input logic [8:0] addr,
                             input logic [15:0] wd, input logic [7:0] swv);
      logic [15:0] ram_old;
      logic [7:0]  seen;
      bit          mapped;
      ram_old = shadow[addr[7:0]];
      if (cmd == MEM_WRITE && addr < 9'd256) shadow[addr[7:0]] = wd;
      if (!rst) begin
         m_led = 8'h00; m_rd = 16'h0000; m_stable = 8'h00; m_run = 0; m_err = 1'b0;
         hist = '{8'h00, 8'h00};
      end else begin
         // The bridge sees each switch value two cycles after it is applied.
         seen = hist.pop_front();
         hist.push_back(swv);
         if (seen != m_stable) begin
            m_run++;
            if (m_run == DEB) begin
               m_stable = seen;
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
         if (cmd == MEM_WRITE && addr == 9'h100) m_led = wd[7:0];
         m_rd = 16'h0000;
         if (cmd == MEM_READ) begin
            if (addr < 9'd256)       m_rd = ram_old;
            else if (addr == 9'h140) m_rd = {8'h00, m_stable};
         end
         mapped = (addr < 9'd256) || addr == 9'h140 || addr == 9'h100;
         if (((cmd == MEM_READ || cmd == MEM_WRITE) && !mapped) ||
             (cmd == MEM_WRITE && addr == 9'h140)) m_err = 1'b1;
      end
   endtask

   // One bus cycle: drive at negedge, check combinational RAM strobe, then
   // check registered outputs just after the posedge.
   task automatic step(input logic rst, input logic [1:0] cmd, input logic [8:0] addr,
                       input logic [15:0] wd, input logic [7:0] swv, input bit use_tab,
                       input logic t_we, input logic [7:0] t_led, input logic [15:0] t_rd);
      logic m_we;
      @(negedge clk);
      reset = rst; mem_cmd = cmd; mem_addr = addr; write_data = wd; sw = swv;
      #1;
      m_we = (cmd == MEM_WRITE) && (addr < 9'd256);
      check("ram_we", {15'h0, ram_we}, {15'h0, use_tab ? t_we : m_we});
      check("ram_addr", {8'h00, ram_addr}, {8'h00, addr[7:0]});
      check("ram_wdata", ram_wdata, wd);
      model_edge(rst, cmd, addr, wd, swv);
      @(posedge clk);
      #1;
      check("ledr", {8'h00, ledr}, {8'h00, use_tab ? t_led : m_led});
      check("read_data", read_data, use_tab ? t_rd : m_rd);
`ifdef MMIO_BUSERR_EN
      check("bus_err", {15'h0, bus_err}, {15'h0, m_err});
`endif
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rst;
      logic [1:0]  cmd;
      logic [8:0]  addr;
      logic [15:0] wd;
      logic [7:0]  swv;
      logic        we;
      logic [7:0]  led;
      logic [15:0] rd;
   } vec_t;

   vec_t tab [$];

   task automatic add(input logic rst, input logic [1:0] cmd, input logic [8:0] addr,
                      input logic [15:0] wd, input logic [7:0] swv,
                      input logic we, input logic [7:0] led, input logic [15:0] rd);
      vec_t v;
      v.rst = rst; v.cmd = cmd; v.addr = addr; v.wd = wd; v.swv = swv;
      v.we = we; v.led = led; v.rd = rd;
      tab.push_back(v);
   endtask

   initial begin
      logic [7:0] cur_sw;
      for (int i = 0; i < 256; i++) begin
         tb_ram[i] = 16'h0000;
         shadow[i] = 16'h0000;
      end
      hist = '{8'h00, 8'h00};
      m_stable = 8'h00; m_run = 0; m_led = 8'h00; m_rd = 16'h0000; m_err = 1'b0;
      reset = 1'b0; mem_cmd = MEM_NONE; mem_addr = '0; write_data = '0; sw = '0;

      //   rst   cmd        addr    wdata     sw     we    led    rd
      add(1'b0, MEM_NONE,  9'h000, 16'h0000, 8'h00, 1'b0, 8'h00, 16'h0000); // reset state
      add(1'b0, MEM_NONE,  9'h000, 16'h0000, 8'h00, 1'b0, 8'h00, 16'h0000);
      add(1'b1, MEM_WRITE, 9'h005, 16'hABCD, 8'h3C, 1'b1, 8'h00, 16'h0000); // RAM write
      add(1'b1, MEM_READ,  9'h005, 16'h0000, 8'h3C, 1'b0, 8'h00, 16'hABCD); // RAM read back
      add(1'b1, MEM_WRITE, 9'h100, 16'h12A5, 8'h3C, 1'b0, 8'hA5, 16'h0000); // LED write
      add(1'b1, MEM_READ,  9'h100, 16'h0000, 8'h3C, 1'b0, 8'hA5, 16'h0000); // LED read = 0
      add(1'b1, MEM_WRITE, 9'h010, 16'h1111, 8'h3C, 1'b1, 8'hA5, 16'h0000);
      add(1'b1, MEM_NONE,  9'h010, 16'h0000, 8'h3C, 1'b0, 8'hA5, 16'h0000);
      add(1'b1, MEM_READ,  9'h140, 16'h0000, 8'h3C, 1'b0, 8'hA5, 16'h003C); // sw held 6 cycles
      add(1'b1, MEM_NONE,  9'h000, 16'h0000, 8'hFF, 1'b0, 8'hA5, 16'h0000); // 3-cycle glitch
      add(1'b1, MEM_NONE,  9'h000, 16'h0000, 8'hFF, 1'b0, 8'hA5, 16'h0000);
      add(1'b1, MEM_NONE,  9'h000, 16'h0000, 8'hFF, 1'b0, 8'hA5, 16'h0000);
      add(1'b1, MEM_READ,  9'h140, 16'h0000, 8'h3C, 1'b0, 8'hA5, 16'h003C);
      add(1'b1, MEM_NONE,  9'h000, 16'h0000, 8'h3C, 1'b0, 8'hA5, 16'h0000);
      add(1'b1, MEM_READ,  9'h140, 16'h0000, 8'h3C, 1'b0, 8'hA5, 16'h003C); // glitch rejected
      for (int i = 0; i < 6; i++)
         add(1'b1, MEM_NONE, 9'h000, 16'h0000, 8'h07, 1'b0, 8'hA5, 16'h0000);
      add(1'b1, MEM_READ,  9'h010, 16'h0000, 8'h07, 1'b0, 8'hA5, 16'h1111); // back-to-back reads
      add(1'b1, MEM_READ,  9'h140, 16'h0000, 8'h07, 1'b0, 8'hA5, 16'h0007);
      add(1'b1, MEM_READ,  9'h140, 16'h0000, 8'h07, 1'b0, 8'hA5, 16'h0007);
      add(1'b0, MEM_READ,  9'h140, 16'h0000, 8'h07, 1'b0, 8'h00, 16'h0000); // reset mid-operation
      add(1'b0, MEM_WRITE, 9'h005, 16'h5555, 8'h07, 1'b1, 8'h00, 16'h0000); // we live in reset
      add(1'b1, MEM_NONE,  9'h000, 16'h0000, 8'h07, 1'b0, 8'h00, 16'h0000);
      add(1'b1, MEM_READ,  9'h140, 16'h0000, 8'h07, 1'b0, 8'h00, 16'h0000); // not yet re-acquired
      add(1'b1, MEM_NONE,  9'h000, 16'h0000, 8'h07, 1'b0, 8'h00, 16'h0000);
      add(1'b1, MEM_NONE,  9'h000, 16'h0000, 8'h07, 1'b0, 8'h00, 16'h0000);
      add(1'b1, MEM_READ,  9'h140, 16'h0000, 8'h07, 1'b0, 8'h00, 16'h0000); // one cycle short
      add(1'b1, MEM_READ,  9'h140, 16'h0000, 8'h07, 1'b0, 8'h00, 16'h0007); // 2+DEB after reset
      add(1'b1, MEM_READ,  9'h005, 16'h0000, 8'h07, 1'b0, 8'h00, 16'h5555);
      add(1'b1, MEM_READ,  9'h1FF, 16'h0000, 8'h07, 1'b0, 8'h00, 16'h0000); // unmapped read
      add(1'b1, MEM_WRITE, 9'h140, 16'hBEEF, 8'h07, 1'b0, 8'h00, 16'h0000); // write to sw port
      add(1'b1, 2'b11,     9'h005, 16'h9999, 8'h07, 1'b0, 8'h00, 16'h0000); // 2'b11 = none
      add(1'b1, MEM_READ,  9'h005, 16'h0000, 8'h07, 1'b0, 8'h00, 16'h5555);
      add(1'b0, MEM_NONE,  9'h000, 16'h0000, 8'h07, 1'b0, 8'h00, 16'h0000);
      add(1'b1, MEM_WRITE, 9'h180, 16'h0001, 8'h07, 1'b0, 8'h00, 16'h0000); // unmapped write
      add(1'b1, MEM_READ,  9'h005, 16'h0000, 8'h07, 1'b0, 8'h00, 16'h5555); // error stays sticky
      add(1'b0, MEM_NONE,  9'h000, 16'h0000, 8'h07, 1'b0, 8'h00, 16'h0000); // reset clears it

      foreach (tab[i])
         step(tab[i].rst, tab[i].cmd, tab[i].addr, tab[i].wd, tab[i].swv, 1'b1,
              tab[i].we, tab[i].led, tab[i].rd);

      // Debounce edge cases: exactly DEB-1 cycles of change is rejected,
      // exactly DEB cycles is accepted.
      for (int i = 0; i < 8; i++)
         step(1'b1, MEM_READ, 9'h140, 16'h0, 8'h55, 1'b0, 1'b0, 8'h0, 16'h0);
      for (int i = 0; i < DEB - 1; i++)
         step(1'b1, MEM_READ, 9'h140, 16'h0, 8'hAA, 1'b0, 1'b0, 8'h0, 16'h0);
      for (int i = 0; i < 8; i++)
         step(1'b1, MEM_READ, 9'h140, 16'h0, 8'h55, 1'b0, 1'b0, 8'h0, 16'h0);
      for (int i = 0; i < DEB; i++)
         step(1'b1, MEM_READ, 9'h140, 16'h0, 8'hAA, 1'b0, 1'b0, 8'h0, 16'h0);
      for (int i = 0; i < 8; i++)
         step(1'b1, MEM_READ, 9'h140, 16'h0, 8'h55, 1'b0, 1'b0, 8'h0, 16'h0);

      // Randomized traffic against the model.
      cur_sw = 8'h55;
      for (int n = 0; n < 800; n++) begin
         logic [1:0]  cmd;
         logic [8:0]  addr;
         logic        rst;
         int          sel;
         cmd = 2'($urandom_range(0, 3));
         sel = $urandom_range(0, 7);
         case (sel)
            0, 1, 2, 3: addr = {1'b0, 4'h0, 4'($urandom_range(0, 15))};
            4:          addr = 9'h140;
            5:          addr = 9'h100;
            6:          addr = {1'b1, 8'($urandom)};
            default:    addr = 9'($urandom);
         endcase
         if ($urandom_range(0, 7) == 0) cur_sw = 8'($urandom);
         rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
         step(rst, cmd, addr, 16'($urandom), cur_sw, 1'b0, 1'b0, 8'h0, 16'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
